// File: rtl/mips_pkg.sv
// Shared MIPS core types: mult/div op encodings, HI/LO controller states, iteration count.
package mips_pkg;

  localparam int unsigned MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } muldiv_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO pair.
module hilo_muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q, op_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [63:0]     acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;

  logic is_mul, in_signed;
  assign is_mul    = (op_q == OpMult) || (op_q == OpMultu);
  assign in_signed = ~op[0];

  // Shift-add: a_q is the multiplicand, b_q the multiplier consumed LSB first.
  logic [32:0] mul_sum;
  logic [63:0] mul_acc;
  logic [31:0] mul_b;
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]};
    if (b_q[0]) mul_sum = mul_sum + {1'b0, a_q};
    mul_acc = {mul_sum, acc_q[31:1]};
    mul_b   = {1'b0, b_q[31:1]};
  end

  // Restoring divide: dividend bits enter rem from the MSB of a_q; acc = {rem, quot}.
  logic [32:0] div_rem_sh;
  logic [31:0] div_rem_sub;
  logic [63:0] div_acc;
  logic [31:0] div_a;
  always_comb begin
    div_rem_sh  = {acc_q[63:32], a_q[31]};
    div_rem_sub = div_rem_sh[31:0] - b_q;
    if (div_rem_sh >= {1'b0, b_q}) div_acc = {div_rem_sub, acc_q[30:0], 1'b1};
    else                           div_acc = {div_rem_sh[31:0], acc_q[30:0], 1'b0};
    div_a = {a_q[30:0], 1'b0};
  end

  // Sign fixup; with a zero divisor rem already equals |rs|, so re-signing restores rs_val.
  logic [63:0] prod;
  logic [31:0] quot, rem, fix_hi, fix_lo;
  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
    quot = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (is_mul) begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end else if (b_q == 32'd0) begin
      fix_hi = rem;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = rem;
      fix_lo = quot;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = muldiv_op_t'(op);
          sign_a_d = in_signed & rs_val[31];
          sign_b_d = in_signed & rt_val[31];
          a_d      = in_signed ? abs32(rs_val) : rs_val;
          b_d      = in_signed ? abs32(rt_val) : rt_val;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      StCalc: begin
        if (is_mul) begin
          acc_d = mul_acc;
          b_d   = mul_b;
        end else begin
          acc_d = div_acc;
          a_d   = div_a;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed plan vectors plus randomized ops vs. arithmetic model.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  hilo_muldiv_ctrl #(.ITER(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Returns {HI, LO} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    logic [31:0] uq, ur;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
    case ($urandom_range(0, 5))
      0:       return specials[$urandom_range(0, 5)];
      1:       return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and waits (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    rhi = hi;
    rlo = lo;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0;
    #12;
    checks++;
    if ({hi, lo} !== 64'h0) begin
      failures++; $display("FAIL reset_hilo: got %h expected %h", {hi, lo}, 64'h0);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  o   [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h64,
                             32'h8000_0000, 32'hFFFF_FF00};
    logic [31:0] b   [6] = '{32'hFFFF_FFFF, 32'h7, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [63:0] exp [6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF,
                             64'h0000_0000_8000_0000, 64'hFFFF_FF00_FFFF_FFFF};
    logic [31:0] rhi, rlo;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(o[i], a[i], b[i], rhi, rlo, lat, bc);
      checks++;
      if ({rhi, rlo} !== exp[i]) begin
        failures++; $display("FAIL directed_%0d_result: got %h expected %h", i, {rhi, rlo}, exp[i]);
      end
      checks++;
      if (lat != 33 || bc != 33) begin
        failures++; $display("FAIL directed_%0d_timing: got lat=%0d busy=%0d expected 33/33",
                             i, lat, bc);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL directed_%0d_done_pulse: got done=%b busy=%b expected 0/0",
                             i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, rhi, rlo;
    logic [63:0] exp;
    int lat, bc;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(o, a, b);
      run_op(o, a, b, rhi, rlo, lat, bc);
      checks++;
      if ({rhi, rlo} !== exp || lat != 33) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d expected %h lat=33",
                 i, o, a, b, {rhi, rlo}, lat, exp);
      end
    end
  endtask

  task automatic test_moves();
    int lat = -1;
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hA5A5_0001;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hA5A5_0001, 32'hA5A5_0001}) begin
      failures++; $display("FAIL move_both: got %h expected %h", {hi, lo},
                           {32'hA5A5_0001, 32'hA5A5_0001});
    end
    @(negedge clk); mthi = 1'b1; rs_val = 32'h0BAD_F00D;
    @(posedge clk); #1; mthi = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h0BAD_F00D, 32'hA5A5_0001}) begin
      failures++; $display("FAIL move_hi_only: got %h expected %h", {hi, lo},
                           {32'h0BAD_F00D, 32'hA5A5_0001});
    end
    // start wins over a simultaneous move
    @(negedge clk); start = 1'b1; mthi = 1'b1; op = 2'b01; rs_val = 32'h1234_0000; rt_val = 32'h2;
    @(posedge clk); #1; start = 1'b0; mthi = 1'b0;
    checks++;
    if (hi !== 32'h0BAD_F00D || busy !== 1'b1) begin
      failures++; $display("FAIL move_vs_start: got hi=%h busy=%b expected hi=0badf00d busy=1",
                           hi, busy);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_2468_0000 || lat != 33) begin
      failures++; $display("FAIL move_vs_start_result: got %h lat=%0d expected %h lat=33",
                           {hi, lo}, lat, 64'h0000_0000_2468_0000);
    end
  endtask

  task automatic test_ignored();
    int dones = 0;
    logic [31:0] rhi = '0, rlo = '0;
    @(negedge clk); mthi = 1'b1; rs_val = 32'hDEAD_BEEF;
    @(posedge clk); #1; mthi = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd3; mthi = 1'b1;
    mtlo = 1'b1;
    @(posedge clk); #1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      failures++; $display("FAIL ignored_hold: got hi=%h busy=%b expected hi=deadbeef busy=1",
                           hi, busy);
    end
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done) begin dones++; rhi = hi; rlo = lo; end
    end
    checks++;
    if (dones != 1 || {rhi, rlo} !== 64'h0000_0000_0000_001E) begin
      failures++; $display("FAIL ignored_result: got dones=%0d %h expected dones=1 %h",
                           dones, {rhi, rlo}, 64'h1E);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h1111_1111;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'b10; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hi, lo} !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid: got %h busy=%b done=%b expected 0 busy=0 done=0",
                           {hi, lo}, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", dones);
    end
    @(negedge clk); mtlo = 1'b1; rs_val = 32'h1234_5678;
    @(posedge clk); #1; mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h0, 32'h1234_5678}) begin
      failures++; $display("FAIL reset_then_mtlo: got %h expected %h", {hi, lo},
                           {32'h0, 32'h1234_5678});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
    int lat1, lat2, bc;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    run_op(2'b00, a1, b1, h1, l1, lat1, bc);
    run_op(2'b10, a2, b2, h2, l2, lat2, bc);
    checks++;
    if ({h1, l1} !== ref_model(2'b00, a1, b1) || lat1 != 33) begin
      failures++; $display("FAIL b2b_first: got %h lat=%0d expected %h lat=33", {h1, l1}, lat1,
                           ref_model(2'b00, a1, b1));
    end
    checks++;
    if ({h2, l2} !== ref_model(2'b10, a2, b2) || lat2 != 33) begin
      failures++; $display("FAIL b2b_second: got %h lat=%0d expected %h lat=33", {h2, l2}, lat2,
                           ref_model(2'b10, a2, b2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_moves();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
